acc_bank: RTL and testbench

- Multi-channel signed accumulator bank for the neuron datapath. Generalises the single 12→28-bit accumulator.
- Each channel sums a stream of signed terms (weighted inputs). The final term of a frame is flagged with `in_last`; the complete sum is then emitted through a one-slot output register and the channel restarts from zero.
- Supports overflow detection with saturate or wrap mode, valid/ready flow control on both sides, and a synchronous clear of all channels.

---
 rtl/acc_pkg.sv | 16 +
 rtl/acc_sat_add.sv | 41 ++++
 rtl/acc_bank.sv | 113 +++++++++++
 tb/tb_acc_bank.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants and saturation-bound helpers for the accumulator bank.
package acc_pkg;

    localparam int IN_W_DEF  = 12;
    localparam int ACC_W_DEF = 28;

    // Largest and smallest two's-complement value representable in w bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational signed add of one term into an accumulator, with overflow
// detection and either clamp-to-bound or two's-complement wrap.
module acc_sat_add
    import acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [IN_W-1:0]  i_term,
    input  logic                    i_saturate,
    output logic signed [ACC_W-1:0] o_result,
    output logic                    o_ovf_now
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(ACC_W));
    localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(ACC_W));

    logic signed [SUM_W-1:0] w_sum;
    logic                    w_hi;
    logic                    w_lo;

    // One guard bit is enough: a single term can push at most one range past.
    assign w_sum = SUM_W'(i_acc) + SUM_W'(i_term);
    assign w_hi  = (w_sum > MAX_V);
    assign w_lo  = (w_sum < MIN_V);

    always_comb begin
        o_ovf_now = w_hi | w_lo;
        o_result  = w_sum[ACC_W-1:0];
        if (i_saturate) begin
            if (w_hi) begin
                o_result = MAX_V[ACC_W-1:0];
            end else if (w_lo) begin
                o_result = MIN_V[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/acc_bank.sv
// Multi-channel signed accumulator bank: per-channel running sums with sticky
// overflow flags, emitting each frame total through a one-slot output register.
module acc_bank
    import acc_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int N_CH     = 4,
    parameter int SATURATE = 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_ovf
);

    localparam int CHK_W = CH_W + 1;
    localparam logic [CHK_W-1:0] N_CH_V = CHK_W'(N_CH);

    logic signed [ACC_W-1:0] r_acc [N_CH];
    logic [N_CH-1:0]         r_ovf;

    logic                    r_out_valid;
    logic [CH_W-1:0]         r_out_ch;
    logic signed [ACC_W-1:0] r_out_data;
    logic                    r_out_ovf;

    logic                    w_ch_ok;
    logic [CH_W-1:0]         w_idx;
    logic                    w_in_ready;
    logic                    w_acc_en;
    logic                    w_xfer;
    logic                    w_sat_mode;
    logic signed [ACC_W-1:0] w_acc_sel;
    logic signed [ACC_W-1:0] w_result;
    logic                    w_ovf_now;

    // Out-of-range channels are consumed by the handshake but never touch state.
    assign w_ch_ok    = ({1'b0, in_ch} < N_CH_V);
    assign w_idx      = w_ch_ok ? in_ch : '0;
    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_acc_en   = in_valid & w_in_ready & ~clr & w_ch_ok;
    assign w_xfer     = r_out_valid & out_ready;
    assign w_sat_mode = (SATURATE != 0);
    assign w_acc_sel  = r_acc[w_idx];

    acc_sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc      (w_acc_sel),
        .i_term     (in_data),
        .i_saturate (w_sat_mode),
        .o_result   (w_result),
        .o_ovf_now  (w_ovf_now)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf <= '0;
        end else if (w_acc_en) begin
            if (in_last) begin
                r_acc[w_idx] <= '0;
                r_ovf[w_idx] <= 1'b0;
            end else begin
                r_acc[w_idx] <= w_result;
                r_ovf[w_idx] <= r_ovf[w_idx] | w_ovf_now;
            end
        end
    end

    // A new last term wins over a drain in the same cycle, keeping out_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_acc_en && in_last) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= w_idx;
            r_out_data  <= w_result;
            r_out_ovf   <= r_ovf[w_idx] | w_ovf_now;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench: three acc_bank instances (28-bit saturate, 14-bit
// saturate, 14-bit wrap) share one input stream and are scored against a model.
module tb_acc_bank;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [11:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [1:0]  och0, och1, och2;
    logic [27:0] od0;
    logic [13:0] od1, od2;
    logic        oo0, oo1, oo2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]        ch;
        logic [2:0]        f;
        logic [2:0][63:0]  d;
    } res_t;

    res_t   q[$];
    longint macc [3][4];
    bit     movf [3][4];

    acc_bank #(.IN_W(12), .ACC_W(28), .N_CH(4), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir0),
        .in_ch(in_ch), .in_data(in_data), .in_last(in_last), .out_valid(ov0),
        .out_ready(out_ready), .out_ch(och0), .out_data(od0), .out_ovf(oo0));

    acc_bank #(.IN_W(12), .ACC_W(14), .N_CH(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
        .in_ch(in_ch), .in_data(in_data), .in_last(in_last), .out_valid(ov1),
        .out_ready(out_ready), .out_ch(och1), .out_data(od1), .out_ovf(oo1));

    acc_bank #(.IN_W(12), .ACC_W(14), .N_CH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir2),
        .in_ch(in_ch), .in_data(in_data), .in_last(in_last), .out_valid(ov2),
        .out_ready(out_ready), .out_ch(och2), .out_data(od2), .out_ovf(oo2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int inst_w(int k);
        return (k == 0) ? 28 : 14;
    endfunction

    function automatic bit inst_sat(int k);
        return (k != 2);
    endfunction

    function automatic logic get_ov(int k);
        case (k) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction

    function automatic logic get_ir(int k);
        case (k) 0: return ir0; 1: return ir1; default: return ir2; endcase
    endfunction

    function automatic int get_ch(int k);
        case (k) 0: return int'(och0); 1: return int'(och1); default: return int'(och2); endcase
    endfunction

    function automatic longint get_data(int k);
        case (k)
            0:       return longint'($signed(od0));
            1:       return longint'($signed(od1));
            default: return longint'($signed(od2));
        endcase
    endfunction

    function automatic logic get_ovf(int k);
        case (k) 0: return oo0; 1: return oo1; default: return oo2; endcase
    endfunction

    // Mathematical add: true sum, then clamp or wrap if outside the w-bit range.
    function automatic longint madd(longint a, longint t, int w, bit sat, output bit o);
        longint mx, mn, s;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s  = a + t;
        o  = 1'b0;
        if (s > mx) begin
            o = 1'b1;
            s = sat ? mx : s - (longint'(1) <<< w);
        end else if (s < mn) begin
            o = 1'b1;
            s = sat ? mn : s + (longint'(1) <<< w);
        end
        return s;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) begin
                macc[k][c] = 0;
                movf[k][c] = 1'b0;
            end
    endtask

    // One clock cycle: drive inputs after the falling edge, score the
    // handshakes before the next rising edge, then advance the model.
    task automatic step(input bit v, input int ch, input int d, input bit last,
                        input bit ordy, input bit c);
        bit     rdy, o;
        longint s;
        res_t   r, nr;
        @(negedge clk);
        in_valid  = v;
        in_ch     = 2'(ch);
        in_data   = 12'(d);
        in_last   = last;
        out_ready = ordy;
        clr       = c;
        #1;
        rdy = (q.size() == 0) || ordy;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (get_ov(k) !== (q.size() != 0)) begin
                errors++;
                $display("FAIL out_valid[%0d] got %b exp %b", k, get_ov(k), q.size() != 0);
            end
            checks++;
            if (get_ir(k) !== rdy) begin
                errors++;
                $display("FAIL in_ready[%0d] got %b exp %b", k, get_ir(k), rdy);
            end
        end
        if (q.size() != 0 && ordy) begin
            r = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (get_ch(k) !== int'(r.ch)) begin
                    errors++;
                    $display("FAIL out_ch[%0d] got %0d exp %0d", k, get_ch(k), r.ch);
                end
                checks++;
                if (get_data(k) !== longint'($signed(r.d[k]))) begin
                    errors++;
                    $display("FAIL out_data[%0d] got %0d exp %0d", k, get_data(k), $signed(r.d[k]));
                end
                checks++;
                if (get_ovf(k) !== r.f[k]) begin
                    errors++;
                    $display("FAIL out_ovf[%0d] got %b exp %b", k, get_ovf(k), r.f[k]);
                end
            end
        end
        if (c) begin
            model_zero();
        end else if (v && rdy) begin
            nr = '0;
            nr.ch = 2'(ch);
            for (int k = 0; k < 3; k++) begin
                s = madd(macc[k][ch], longint'(d), inst_w(k), inst_sat(k), o);
                if (last) begin
                    nr.d[k] = s;
                    nr.f[k] = movf[k][ch] | o;
                    macc[k][ch] = 0;
                    movf[k][ch] = 1'b0;
                end else begin
                    macc[k][ch] = s;
                    movf[k][ch] = movf[k][ch] | o;
                end
            end
            if (last) q.push_back(nr);
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, 0, 1'b0, ordy, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1;
        model_zero();
        #3;
        checks++;
        if ({ov0, ov1, ov2, oo0, oo1, oo2} !== 6'b0 || od0 !== 28'd0 || od1 !== 14'd0
            || od2 !== 14'd0 || och0 !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b%b%b d=%0d ch=%0d exp all zero", ov0, ov1, ov2, od0, och0);
        end
        checks++;
        if ({ir0, ir1, ir2} !== 3'b111) begin
            errors++;
            $display("FAIL reset_in_ready got %b%b%b exp 111", ir0, ir1, ir2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_frame();
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2, 100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2, -30, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2, 7, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if (ov0 !== 1'b1 || och0 !== 2'd2 || $signed(od0) !== 28'sd77 || oo0 !== 1'b0) begin
            errors++;
            $display("FAIL single_frame got v=%b ch=%0d d=%0d o=%b exp v=1 ch=2 d=77 o=0",
                     ov0, och0, $signed(od0), oo0);
        end
        step(1'b1, 2, 5, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if ($signed(od0) !== 28'sd5) begin
            errors++;
            $display("FAIL single_restart got %0d exp 5", $signed(od0));
        end
    endtask

    task automatic test_interleave();
        step(1'b1, 0, 10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1, -5, 1'b0, 1'b1, 1'b0);
        step(1'b1, 0, 20, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1, -6, 1'b1, 1'b1, 1'b0);
        checks++;
        if (och0 !== 2'd0 || $signed(od0) !== 28'sd30) begin
            errors++;
            $display("FAIL interleave_first got ch=%0d d=%0d exp ch=0 d=30", och0, $signed(od0));
        end
        idle(1'b1);
        checks++;
        if (och0 !== 2'd1 || $signed(od0) !== -28'sd11) begin
            errors++;
            $display("FAIL interleave_second got ch=%0d d=%0d exp ch=1 d=-11", och0, $signed(od0));
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 5; n++) step(1'b1, 1, 2047, n == 4, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if ($signed(od0) !== 28'sd10235 || oo0 !== 1'b0 || $signed(od1) !== 14'sd8191
            || oo1 !== 1'b1 || $signed(od2) !== -14'sd6149 || oo2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got %0d/%b %0d/%b %0d/%b exp 10235/0 8191/1 -6149/1",
                     $signed(od0), oo0, $signed(od1), oo1, $signed(od2), oo2);
        end
        for (int n = 0; n < 5; n++) step(1'b1, 1, -2048, n == 4, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if ($signed(od0) !== -28'sd10240 || oo0 !== 1'b0 || $signed(od1) !== -14'sd8192
            || oo1 !== 1'b1 || $signed(od2) !== 14'sd6144 || oo2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got %0d/%b %0d/%b %0d/%b exp -10240/0 -8192/1 6144/1",
                     $signed(od0), oo0, $signed(od1), oo1, $signed(od2), oo2);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1, 42, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 2, 99, 1'b0, 1'b0, 1'b0);
            checks++;
            if (ov0 !== 1'b1 || ir0 !== 1'b0 || $signed(od0) !== 28'sd42 || och0 !== 2'd1) begin
                errors++;
                $display("FAIL backpressure_hold cyc %0d got v=%b rdy=%b d=%0d ch=%0d exp v=1 rdy=0 d=42 ch=1",
                         n, ov0, ir0, $signed(od0), och0);
            end
        end
        step(1'b1, 0, 8, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if (ov0 !== 1'b1 || $signed(od0) !== 28'sd8 || och0 !== 2'd0) begin
            errors++;
            $display("FAIL backpressure_release got v=%b d=%0d ch=%0d exp v=1 d=8 ch=0",
                     ov0, $signed(od0), och0);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 3, 500, 1'b0, 1'b1, 1'b0);
        step(1'b1, 0, 6, 1'b1, 1'b1, 1'b0);
        step(1'b1, 3, 9, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3, 9, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ov0 !== 1'b1 || $signed(od0) !== 28'sd6 || och0 !== 2'd0 || ir0 !== 1'b1) begin
            errors++;
            $display("FAIL clear_output_kept got v=%b d=%0d ch=%0d rdy=%b exp v=1 d=6 ch=0 rdy=1",
                     ov0, $signed(od0), och0, ir0);
        end
        step(1'b1, 3, 4, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if ($signed(od0) !== 28'sd4 || oo0 !== 1'b0 || och0 !== 2'd3) begin
            errors++;
            $display("FAIL clear_restart got d=%0d o=%b ch=%0d exp d=4 o=0 ch=3", $signed(od0), oo0, och0);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 0, 77, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2, 5, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ov0, ov1, ov2} !== 3'b0 || od0 !== 28'd0 || och0 !== 2'd0 || oo0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b%b%b d=%0d ch=%0d o=%b exp all zero",
                     ov0, ov1, ov2, od0, och0, oo0);
        end
        q.delete();
        model_zero();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if ($signed(od0) !== 28'sd1 || och0 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_restart got d=%0d ch=%0d exp d=1 ch=0", $signed(od0), och0);
        end
    endtask

    task automatic test_random();
        int d;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0)
                d = ($urandom_range(0, 1) == 0) ? 2047 : -2048;
            else
                d = int'($urandom_range(0, 4095)) - 2048;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), d,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_interleave();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
